// File: rtl/word_table_loader_pkg.sv
// Shared constants and types for the twiddle/constant table loader.
//   OVERALL_BITS / LOGQ_MAX : width of one modular constant
//   FFT_* / NTT_*           : table region layout (FFT at 0, NTT regions packed after)
//   NUM_REGIONS             : FFT region plus eight NTT constant sets
//   state_t                 : loader FSM state encoding
package word_table_loader_pkg;

    localparam int unsigned OVERALL_BITS  = 32;
    localparam int unsigned LOGQ_MAX      = OVERALL_BITS;

    localparam int unsigned FFT_WORDS_DEF = 129;
    localparam int unsigned NTT_BASE_DEF  = 129;
    localparam int unsigned NTT_WORDS_DEF = 40;
    localparam int unsigned NUM_REGIONS   = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/word_table_loader_table_ram.sv
// Simple dual-port table storage: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   wr_en/addr/data   : write port
//   rd_addr           : read address, sampled every cycle
//   rd_data           : registered read data
module word_table_loader_table_ram
    import word_table_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/word_table_loader.sv
// Loads FFT twiddles or one of eight NTT constant sets into the shared table
// from a valid/ready word stream, and serves registered reads to the twiddle
// generator at all times.
//   cmd_valid/cmd_ready/cmd_region : load command (0 = FFT, 1..8 = NTT set)
//   s_valid/s_ready/s_data         : table word stream
//   rd_addr/rd_data                : registered read port
//   busy, done, err                : status (done/err are one-cycle pulses)
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for a command, cmd_ready high
// ST_LOAD | accepting words, writing table[base+idx]
// ST_DONE | single cycle, done pulse high, back to IDLE
module word_table_loader
    import word_table_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_ROM = 9,
    parameter int unsigned DATA_W         = 2*OVERALL_BITS,
    parameter int unsigned FFT_WORDS      = FFT_WORDS_DEF,
    parameter int unsigned NTT_BASE       = NTT_BASE_DEF,
    parameter int unsigned NTT_WORDS      = NTT_WORDS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [3:0]                cmd_region,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    input  logic [ADDR_WIDTH_ROM-1:0] rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH_ROM-1:0] base_q, base_d;
    logic [ADDR_WIDTH_ROM-1:0] last_q, last_d;
    logic [ADDR_WIDTH_ROM-1:0] idx_q, idx_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic                      wr_fire;
    logic [ADDR_WIDTH_ROM-1:0] wr_addr;
    logic [ADDR_WIDTH_ROM-1:0] ntt_base;

    assign s_ready   = (state_q == ST_LOAD);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // A reset in the same cycle as a handshake must not land a word.
    assign wr_fire = s_valid && s_ready && !rst;
    assign wr_addr = base_q + idx_q;

    // Only meaningful for regions 1..8; other values are never used.
    assign ntt_base = ADDR_WIDTH_ROM'(NTT_BASE + NTT_WORDS * (int'(cmd_region) - 1));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        last_d  = last_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_region == 4'd0) begin
                        base_d  = '0;
                        last_d  = ADDR_WIDTH_ROM'(FFT_WORDS - 1);
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else if (cmd_region < 4'(NUM_REGIONS)) begin
                        base_d  = ntt_base;
                        last_d  = ADDR_WIDTH_ROM'(NTT_WORDS - 1);
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (wr_fire) begin
                    idx_d = idx_q + ADDR_WIDTH_ROM'(1);
                    if (idx_q == last_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    word_table_loader_table_ram #(
        .ADDR_W (ADDR_WIDTH_ROM),
        .DATA_W (DATA_W)
    ) u_table_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (s_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_word_table_loader.sv
// Directed bench for word_table_loader: region loads, random stalls, rejected
// command, mid-load reset and same-address read/write.
module tb_word_table_loader;

    localparam int AW = 9;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_region;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          err;

    logic [DW-1:0] model [0:511];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    word_table_loader dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_region (cmd_region),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check_vec(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input int a, input string tag);
        rd_addr = AW'(a);
        tick;
        check_vec(tag, rd_data, model[a]);
    endtask

    task automatic send_cmd(input int r);
        cmd_valid  = 1'b1;
        cmd_region = 4'(r);
        tick;
        cmd_valid  = 1'b0;
    endtask

    // Streams n words d0, d0+1, ... to addresses addr0.. and checks done timing.
    task automatic load_words(input int n, input int addr0, input logic [DW-1:0] d0,
                              input bit rnd, input string tag);
        int hs = 0;
        int cyc = 0;
        bit early = 1'b0;
        while (hs < n && cyc < 2000) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = d0 + DW'(hs);
            if (s_valid && s_ready) begin
                model[addr0 + hs] = s_data;
                hs++;
            end
            tick;
            cyc++;
            if (hs < n && done) early = 1'b1;
        end
        s_valid = 1'b0;
        check_vec({tag, " handshakes"}, DW'(hs), DW'(n));
        check_vec({tag, " early_done"}, DW'(early), '0);
        check_vec({tag, " done"}, DW'(done), DW'(1));
        tick;
        check_vec({tag, " done_drop"}, DW'(done), '0);
        check_vec({tag, " idle"}, DW'({busy, s_ready, cmd_ready}), DW'(3'b001));
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_region = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        rd_addr    = '0;
        tick;
        tick;
        check_vec("rst rd_data", rd_data, '0);
        check_vec("rst status", DW'({busy, done, err, cmd_ready, s_ready}), DW'(5'b00010));
        rst = 1'b0;

        // FFT region, words 0..128
        send_cmd(0);
        check_vec("fft busy", DW'({busy, s_ready, cmd_ready}), DW'(3'b110));
        load_words(129, 0, '0, 1'b0, "fft");
        read_chk(0, "fft rd0");
        read_chk(128, "fft rd128");
        read_chk(64, "fft rd64");

        // Fill all NTT regions with a known background pattern
        for (int r = 1; r <= 8; r++) begin
            send_cmd(r);
            load_words(40, 129 + 40*(r-1), DW'(32'h5000 + 129 + 40*(r-1)), 1'b0, "pre");
        end
        read_chk(129, "pre rd129");
        read_chk(448, "pre rd448");

        // Region 3 -> 209..248
        send_cmd(3);
        load_words(40, 209, DW'(32'hA000), 1'b0, "r3");
        read_chk(209, "r3 rd209");
        read_chk(248, "r3 rd248");
        read_chk(208, "r3 rd208");
        read_chk(249, "r3 rd249");

        // Region 8 with stalls -> 409..448
        send_cmd(8);
        load_words(40, 409, DW'(32'hC000), 1'b1, "r8");
        read_chk(408, "r8 rd408");
        read_chk(409, "r8 rd409");
        read_chk(430, "r8 rd430");
        read_chk(448, "r8 rd448");

        // Rejected region
        send_cmd(9);
        check_vec("r9 err", DW'(err), DW'(1));
        check_vec("r9 state", DW'({busy, cmd_ready, s_ready}), DW'(3'b010));
        tick;
        check_vec("r9 err_drop", DW'(err), '0);
        check_vec("r9 ready", DW'(cmd_ready), DW'(1));
        send_cmd(15);
        check_vec("r15 err", DW'(err), DW'(1));
        tick;
        read_chk(0, "r9 rd0");
        read_chk(129, "r9 rd129");

        // Same-address read/write, region 5 base 289
        send_cmd(5);
        rd_addr = AW'(289);
        s_valid = 1'b1;
        s_data  = DW'(32'hD000);
        tick;
        s_valid = 1'b0;
        check_vec("rbw old", rd_data, model[289]);
        model[289] = DW'(32'hD000);
        tick;
        check_vec("rbw new", rd_data, DW'(32'hD000));
        load_words(39, 290, DW'(32'hD001), 1'b0, "r5");
        read_chk(328, "r5 rd328");

        // Reset after 10 words of region 1
        send_cmd(1);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(32'hB000 + i);
            model[129 + i] = s_data;
            tick;
        end
        s_data = DW'(64'hDEAD);
        rst    = 1'b1;
        tick;
        rst     = 1'b0;
        s_valid = 1'b0;
        check_vec("rst busy", DW'({busy, cmd_ready, s_ready, done}), DW'(4'b0100));
        tick;
        check_vec("rst idle", DW'({busy, cmd_ready, s_ready}), DW'(3'b010));
        read_chk(129, "rst rd129");
        read_chk(138, "rst rd138");
        read_chk(139, "rst rd139");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
